// File: rtl/zrb_uart_rx_os.sv
// UART receiver with 16x oversampling and 2-of-3 majority voting on ticks 7..9 of each bit.
// Delivers words through a valid/ready handshake and pulses framing and overrun errors.
module zrb_uart_rx_os #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 samp7_q, samp7_d;
    logic                 samp8_q, samp8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;

    logic                 maj;
    logic                 mid_tick;
    logic                 end_tick;
    logic                 stop_decide;
    logic                 load_word;

    // The third vote is the live synchronized sample taken on the tick-9 edge.
    assign maj      = (samp7_q & samp8_q) | (samp7_q & rx_s_q) | (samp8_q & rx_s_q);
    assign mid_tick = baud_tick && (tick_q == 4'd9);
    assign end_tick = baud_tick && (tick_q == 4'd15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_cnt_d   = bit_cnt_q;
        samp7_d     = samp7_q;
        samp8_d     = samp8_q;
        shift_d     = shift_q;
        stop_decide = 1'b0;

        if (baud_tick && (state_q != IDLE)) begin
            tick_d = tick_q + 4'd1;
            if (tick_q == 4'd7) samp7_d = rx_s_q;
            if (tick_q == 4'd8) samp8_d = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                tick_d = 4'd0;
                if (baud_tick && !rx_s_q) state_d = START;
            end
            START: begin
                if (mid_tick && maj) begin
                    state_d = IDLE;
                    tick_d  = 4'd0;
                end else if (end_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (mid_tick) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (end_tick) begin
                    if (bit_cnt_q == LAST_BIT) state_d = STOP;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                // Leaving at mid-bit leaves half a bit to catch a back-to-back start edge.
                if (mid_tick) begin
                    stop_decide = 1'b1;
                    state_d     = IDLE;
                    tick_d      = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_word = stop_decide && maj && (!valid_q || data_ready);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;

        if (valid_q && data_ready) valid_d = 1'b0;
        if (load_word) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end
        if (stop_decide && !maj) ferr_d = 1'b1;
        if (stop_decide && maj && valid_q && !data_ready) oerr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tick_q    <= 4'd0;
            bit_cnt_q <= 3'd0;
            samp7_q   <= 1'b1;
            samp8_q   <= 1'b1;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            samp7_q   <= samp7_d;
            samp8_q   <= samp8_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign framing_err = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_zrb_uart_rx_os.sv
// Directed bench for zrb_uart_rx_os: serial frames driven 16 baud ticks per bit,
// baud tick every 4 clocks, outputs checked with immediate assertions.
module tb_zrb_uart_rx_os;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       framing_err;
    logic       overrun_err;
    logic       busy;

    logic [1:0] div = 2'd0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         dv_cyc = 0;
    int         fe0, ov0, dv0;
    int         total = 0;
    int         bad = 0;

    zrb_uart_rx_os #(.DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset_n),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .framing_err(framing_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Tick changes on the falling edge so it is stable at every rising edge.
    always @(negedge clk) begin
        div       <= div + 2'd1;
        baud_tick <= (div == 2'd3);
    end

    always @(negedge clk) begin
        if (framing_err) fe_cnt <= fe_cnt + 1;
        if (overrun_err) ov_cnt <= ov_cnt + 1;
        if (data_valid)  dv_cyc <= dv_cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (baud_tick !== 1'b1);
        end
        #1;
    endtask

    // Samples land on the 9th..11th tick of each bit; flip drives the 10th inverted.
    task automatic send_bit(input logic v, input logic flip);
        rx = v;
        if (flip) begin
            wait_ticks(9);
            rx = ~v;
            wait_ticks(1);
            rx = v;
            wait_ticks(6);
        end else begin
            wait_ticks(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic flip);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], flip);
        send_bit(stop_v, 1'b0);
        rx = 1'b1;
    endtask

    task automatic snap();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        dv0 = dv_cyc;
    endtask

    initial begin
        logic [7:0] abort_word;
        abort_word = 8'h0F;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_framing_err", 32'(framing_err), 32'h0);
        check("rst_overrun_err", 32'(overrun_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        wait_ticks(4);

        // Clean frame 0xA5, consumer ready
        data_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(24);
        check("a5_data_out", 32'(data_out), 32'hA5);
        check("a5_valid_cycles", 32'(dv_cyc - dv0), 32'd1);
        check("a5_valid_now", 32'(data_valid), 32'h0);
        check("a5_framing", 32'(fe_cnt - fe0), 32'd0);
        check("a5_overrun", 32'(ov_cnt - ov0), 32'd0);

        // Four-tick low glitch in IDLE is rejected
        snap();
        rx = 1'b0;
        wait_ticks(4);
        check("glitch_busy_high", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_ticks(7);
        check("glitch_busy_low", 32'(busy), 32'h0);
        wait_ticks(24);
        check("glitch_valid", 32'(dv_cyc - dv0), 32'd0);
        check("glitch_framing", 32'(fe_cnt - fe0), 32'd0);
        check("glitch_overrun", 32'(ov_cnt - ov0), 32'd0);

        // Frame 0x3C with a low stop bit
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(24);
        check("fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("fe_valid_cycles", 32'(dv_cyc - dv0), 32'd0);
        check("fe_data_out", 32'(data_out), 32'hA5);
        check("fe_overrun", 32'(ov_cnt - ov0), 32'd0);

        // Back-to-back 0x11 then 0x22 while the consumer stalls
        data_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0);
        check("ov_first_data", 32'(data_out), 32'h11);
        check("ov_first_valid", 32'(data_valid), 32'h1);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_ticks(24);
        check("ov_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("ov_framing", 32'(fe_cnt - fe0), 32'd0);
        check("ov_data_held", 32'(data_out), 32'h11);
        check("ov_valid_held", 32'(data_valid), 32'h1);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ov_accept_valid", 32'(data_valid), 32'h0);
        check("ov_accept_data", 32'(data_out), 32'h11);

        // 0x55 with the middle sample of every data bit inverted
        wait_ticks(4);
        snap();
        send_frame(8'h55, 1'b1, 1'b1);
        wait_ticks(24);
        check("maj_data_out", 32'(data_out), 32'h55);
        check("maj_valid_cycles", 32'(dv_cyc - dv0), 32'd1);
        check("maj_framing", 32'(fe_cnt - fe0), 32'd0);
        check("maj_overrun", 32'(ov_cnt - ov0), 32'd0);

        // Reset during data bit 4, then a clean 0x81
        snap();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(abort_word[i], 1'b0);
        rx = abort_word[4];
        wait_ticks(5);
        check("mid_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_data_out", 32'(data_out), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        rx = 1'b1;
        wait_ticks(24);
        check("mid_abandon_valid", 32'(dv_cyc - dv0), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(24);
        check("post_data_out", 32'(data_out), 32'h81);
        check("post_valid_cycles", 32'(dv_cyc - dv0), 32'd1);
        check("post_framing", 32'(fe_cnt - fe0), 32'd0);
        check("post_overrun", 32'(ov_cnt - ov0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zrb_uart_rx_os.md
ZRB_UART_RX_OS -- requirements
Module: zrb_uart_rx_os

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8), LSB first.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port baud_tick  input  1  one-clk enable pulse at 16x baud rate.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data_out  output  DATA_BITS  received word, LSB-aligned.
REQ-007 SHALL have port data_valid  output  1  data_out holds an unconsumed word.
REQ-008 SHALL have port data_ready  input  1  consumer accepts the word on clk when data_valid is high.
REQ-009 SHALL have port framing_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 SHALL have port overrun_err  output  1  one-clk pulse: word completed while the previous word was still unaccepted.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-013 SHALL implement states IDLE, START, DATA and STOP, with a 4-bit tick counter (0..15) that advances only on baud_tick.
REQ-014 SHALL, in IDLE on a baud_tick with rx_s==0, enter START with the tick counter cleared to 0.
REQ-015 SHALL take three samples per bit, at tick counts 7, 8 and 9, and use the 2-of-3 majority as the bit value.
REQ-016 SHALL, in START after the tick-9 sample, return to IDLE (glitch rejected, no outputs) if the majority is 1.
REQ-017 SHALL, in START with majority 0, enter DATA at tick 15 with the counter wrapped to 0 and the bit counter cleared.
REQ-018 SHALL, in DATA, shift each majority bit into the shift register LSB first and, at tick 15, advance the bit counter; after bit DATA_BITS-1 it enters STOP.
REQ-019 SHALL, in STOP, decide at tick 9 and return to IDLE on the same clk, giving half a bit of margin for back-to-back frames.
REQ-020 SHALL, at the STOP decision with majority 1 and either data_valid low or data_ready high that clk, load data_out and set data_valid on the next clk edge.
REQ-021 SHALL, at the STOP decision with majority 0, pulse framing_err for one clk, discard the word and leave data_out and data_valid unchanged.
REQ-022 SHALL, at the STOP decision with majority 1 while data_valid is high and data_ready is low, pulse overrun_err for one clk, discard the new word and keep the old one.
REQ-023 SHALL clear data_valid on a clk with data_valid and data_ready both high, unless REQ-020 reloads it on the same edge, in which case data_valid stays high with the new word.
REQ-024 SHALL ignore baud_tick==0 cycles completely; the counter and samples hold.
REQ-025 SHALL be ready to detect the next start edge on the first baud_tick after returning to IDLE.

Reset
REQ-026 SHALL, while reset is low, force state=IDLE, tick and bit counters=0, shift register=0, data_out=0, data_valid=0, framing_err=0, overrun_err=0, busy=0, and both synchronizer flops=1.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame with no error pulse and with no word delivered after release.

Verification
REQ-028 SHALL be covered by a scenario in which frame 0x A5 with a valid stop bit and data_ready=1 leads to data_out=0xA5 and one data_valid cycle, with framing_err=overrun_err=0.
REQ-029 SHALL be covered by a scenario in which a low glitch on rx lasting 4 baud_ticks in IDLE leads to a return to IDLE with busy low by tick 9 and no outputs.
REQ-030 SHALL be covered by a scenario in which frame 0x3C with stop bit=0 leads to one framing_err pulse, data_valid staying 0 and data_out unchanged.
REQ-031 SHALL be covered by a scenario in which frames 0x11 then 0x22 back-to-back with data_ready=0 lead to data_out=0x11 held, one overrun_err pulse on the second stop, and 0x11 delivered when data_ready rises.
REQ-032 SHALL be covered by a scenario in which a single-sample flip at tick 8 of each data bit of 0x55 still yields data_out=0x55.
REQ-033 SHALL be covered by a scenario in which reset is pulsed low during data bit 4, followed by a clean frame 0x81, leading to only 0x81 being delivered and no error pulses.
